// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a controller and serial_adder.
// The controller drives the master side. The adder drives the slave side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice plus a registered carry produce
// A + B + cin over WIDTH/DIGIT cycles, with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N     = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : gBadParams
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [WIDTH-1:0] sumSr_q;
    logic             carry_q;
    logic             aMsb_q;
    logic             bMsb_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [CNT_W-1:0] cnt_q;

    logic [DIGIT:0]   digit_d;
    logic [WIDTH-1:0] sumSr_d;
    logic             lastDigit_d;

    // New digits enter at the top, so the first digit lands at the bottom after N shifts.
    always_comb begin
        digit_d     = {1'b0, aSr_q[DIGIT-1:0]} + {1'b0, bSr_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        sumSr_d     = (WIDTH'(digit_d[DIGIT-1:0]) << (WIDTH - DIGIT)) | (sumSr_q >> DIGIT);
        lastDigit_d = (cnt_q == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            aSr_q      <= '0;
            bSr_q      <= '0;
            sumSr_q    <= '0;
            carry_q    <= 1'b0;
            aMsb_q     <= 1'b0;
            bMsb_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        aSr_q   <= bus.a;
                        bSr_q   <= bus.b;
                        carry_q <= bus.cin;
                        aMsb_q  <= bus.a[WIDTH-1];
                        bMsb_q  <= bus.b[WIDTH-1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sumSr_q <= sumSr_d;
                    aSr_q   <= aSr_q >> DIGIT;
                    bSr_q   <= bSr_q >> DIGIT;
                    carry_q <= digit_d[DIGIT];
                    cnt_q   <= cnt_q + 1'b1;
                    // The incoming digit's top bit becomes the sum MSB on this final edge.
                    if (lastDigit_d) begin
                        overflow_q <= (aMsb_q == bMsb_q) && (digit_d[DIGIT-1] != aMsb_q);
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sumSr_q;
    assign bus.cout     = carry_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder in three configurations (8/1, 8/4, 4/1). Results are
// compared against plain-arithmetic expectations.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if81 ();
    serial_adder_if #(.WIDTH(8)) if84 ();
    serial_adder_if #(.WIDTH(4)) if41 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst(rst), .bus(if81.slave));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst(rst), .bus(if84.slave));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u41 (.clk(clk), .rst(rst), .bus(if41.slave));

    // Reference: {overflow, cout, sum} of a w-bit add, zero-extended to 8 bits.
    function automatic logic [9:0] refAdd(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
        int unsigned total;
        int unsigned mask;
        logic [7:0]  s;
        logic        co;
        logic        ov;
        mask  = (32'd1 << w) - 32'd1;
        total = 32'(a) + 32'(b) + 32'(c);
        s     = 8'(total & mask);
        co    = total[w];
        ov    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic applyStimulus(input int sel, input logic st, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
        case (sel)
            0: begin if81.start = st; if81.a = a; if81.b = b; if81.cin = c; end
            1: begin if84.start = st; if84.a = a; if84.b = b; if84.cin = c; end
            default: begin if41.start = st; if41.a = a[3:0]; if41.b = b[3:0]; if41.cin = c; end
        endcase
    endtask

    task automatic sampleOutputs(input int sel, output logic bsy, output logic dn,
                                 output logic [7:0] s, output logic co, output logic ov);
        case (sel)
            0: begin bsy = if81.busy; dn = if81.done; s = if81.sum; co = if81.cout; ov = if81.overflow; end
            1: begin bsy = if84.busy; dn = if84.done; s = if84.sum; co = if84.cout; ov = if84.overflow; end
            default: begin
                bsy = if41.busy; dn = if41.done; s = {4'b0, if41.sum}; co = if41.cout; ov = if41.overflow;
            end
        endcase
    endtask

    // Runs one operation from IDLE; returns the outputs seen in the done cycle.
    task automatic runOp(input int sel, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit scramble, output logic [7:0] s, output logic co, output logic ov,
                         output int lat, output int bc, output logic dnAfter, output logic bsyAfter);
        logic       bsy;
        logic       dn;
        logic [7:0] ts;
        logic       tco;
        logic       tov;
        applyStimulus(sel, 1'b1, a, b, c);
        @(posedge clk); #1;
        if (scramble) applyStimulus(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        else applyStimulus(sel, 1'b0, a, b, c);
        sampleOutputs(sel, bsy, dn, s, co, ov);
        bc  = bsy ? 1 : 0;
        lat = 0;
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (scramble) applyStimulus(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            sampleOutputs(sel, bsy, dn, s, co, ov);
            if (bsy) bc++;
        end
        @(posedge clk); #1;
        sampleOutputs(sel, bsyAfter, dnAfter, ts, tco, tov);
    endtask

    task automatic test_reset();
        logic       bsy, dn, co, ov;
        logic [7:0] s;
        for (int sel = 0; sel < 3; sel++) applyStimulus(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        #2 rst = 1'b1;
        #2;
        for (int sel = 0; sel < 3; sel++) begin
            sampleOutputs(sel, bsy, dn, s, co, ov);
            checks++;
            if ({bsy, dn, co, ov, s} !== 12'h000) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: got busy=%b done=%b cout=%b ovf=%b sum=%h, expected all 0",
                         sel, bsy, dn, co, ov, s);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] s;
        logic       co, ov, dnA, bsyA;
        int         lat, bc;
        logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h80};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] te [3] = '{{2'b01, 8'h00}, {2'b10, 8'h80}, {2'b11, 8'h01}};
        for (int i = 0; i < 3; i++) begin
            runOp(0, ta[i], tb[i], tc[i], 1'b0, s, co, ov, lat, bc, dnA, bsyA);
            checks++;
            if ({ov, co, s} !== te[i]) begin
                errors++;
                $display("[TB] FAIL directed%0d result: got ovf,cout,sum=%h expected %h", i, {ov, co, s}, te[i]);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("[TB] FAIL directed%0d latency: got %0d expected 8", i, lat);
            end
            checks++;
            if (bc !== 9) begin
                errors++;
                $display("[TB] FAIL directed%0d busy cycles: got %0d expected 9", i, bc);
            end
            checks++;
            if ({dnA, bsyA} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL directed%0d after done: got done=%b busy=%b expected 0 0", i, dnA, bsyA);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] s, a, b;
        logic       c, co, ov, dnA, bsyA;
        int         lat, bc;
        logic [9:0] exp;
        for (int i = 0; i < 25; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            c   = 1'($urandom);
            exp = refAdd(8, a, b, c);
            runOp(0, a, b, c, 1'b0, s, co, ov, lat, bc, dnA, bsyA);
            checks++;
            if ({ov, co, s} !== exp || lat !== 8) begin
                errors++;
                $display("[TB] FAIL random %h+%h+%b: got %h lat=%0d expected %h lat=8", a, b, c, {ov, co, s}, lat, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic       bsy, dn, co, ov;
        logic [7:0] s;
        int         lat, extraDone, extraBusy;
        applyStimulus(0, 1'b1, 8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 8'h12, 8'h34, 1'b0);
        lat = 0;
        dn  = 1'b0;
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            sampleOutputs(0, bsy, dn, s, co, ov);
            if (lat == 3) applyStimulus(0, 1'b1, 8'hF0, 8'h0F, 1'b1);
            else if (lat == 4) applyStimulus(0, 1'b0, 8'hF0, 8'h0F, 1'b1);
        end
        checks++;
        if (lat !== 8 || {ov, co, s} !== {2'b00, 8'h46}) begin
            errors++;
            $display("[TB] FAIL start during ADD: got lat=%0d res=%h expected lat=8 res=046", lat, {ov, co, s});
        end
        // Request during the DONE cycle must also be dropped.
        applyStimulus(0, 1'b1, 8'hAA, 8'h11, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 8'hAA, 8'h11, 1'b0);
        extraDone = 0;
        extraBusy = 0;
        for (int i = 0; i < 12; i++) begin
            sampleOutputs(0, bsy, dn, s, co, ov);
            if (dn) extraDone++;
            if (bsy) extraBusy++;
            @(posedge clk); #1;
        end
        checks++;
        if (extraDone !== 0 || extraBusy !== 0 || s !== 8'h46) begin
            errors++;
            $display("[TB] FAIL start during DONE: got done=%0d busy=%0d sum=%h expected 0 0 46", extraDone, extraBusy, s);
        end
    endtask

    task automatic test_back_to_back();
        logic       bsy, dn, co, ov;
        logic [7:0] s;
        int         doneAt[$];
        logic [9:0] exp;
        exp = refAdd(8, 8'h5A, 8'h3C, 1'b1);
        applyStimulus(0, 1'b1, 8'h5A, 8'h3C, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            sampleOutputs(0, bsy, dn, s, co, ov);
            if (dn) begin
                doneAt.push_back(k);
                checks++;
                if ({ov, co, s} !== exp) begin
                    errors++;
                    $display("[TB] FAIL back-to-back result at cycle %0d: got %h expected %h", k, {ov, co, s}, exp);
                end
            end
        end
        applyStimulus(0, 1'b0, 8'h5A, 8'h3C, 1'b1);
        checks++;
        if (doneAt.size() !== 4) begin
            errors++;
            $display("[TB] FAIL back-to-back count: got %0d done pulses expected 4", doneAt.size());
        end
        for (int i = 1; i < doneAt.size(); i++) begin
            checks++;
            if (doneAt[i] - doneAt[i-1] !== 10) begin
                errors++;
                $display("[TB] FAIL back-to-back spacing: got %0d cycles expected 10", doneAt[i] - doneAt[i-1]);
            end
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_hold();
        logic       bsy, dn, co, ov;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
            sampleOutputs(0, bsy, dn, s, co, ov);
            checks++;
            if ({bsy, dn, co, ov, s} !== {4'b0001, 8'h97}) begin
                errors++;
                $display("[TB] FAIL idle hold: got busy=%b done=%b cout=%b ovf=%b sum=%h expected 0 0 0 1 97",
                         bsy, dn, co, ov, s);
            end
        end
    endtask

    task automatic test_async_reset();
        logic       bsy, dn, co, ov, dnA, bsyA;
        logic [7:0] s;
        int         lat, bc;
        runOp(0, 8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bc, dnA, bsyA);
        applyStimulus(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        repeat (4) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        sampleOutputs(0, bsy, dn, s, co, ov);
        checks++;
        if ({bsy, dn, co, ov, s} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL async reset mid-ADD: got busy=%b done=%b cout=%b ovf=%b sum=%h expected all 0",
                     bsy, dn, co, ov, s);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        sampleOutputs(0, bsy, dn, s, co, ov);
        checks++;
        if ({bsy, dn, co, ov, s} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL after reset release: got busy=%b done=%b sum=%h expected idle zeros", bsy, dn, s);
        end
        runOp(0, 8'h21, 8'h43, 1'b0, 1'b0, s, co, ov, lat, bc, dnA, bsyA);
        checks++;
        if ({ov, co, s} !== {2'b00, 8'h64} || lat !== 8) begin
            errors++;
            $display("[TB] FAIL post-reset op: got %h lat=%0d expected 064 lat=8", {ov, co, s}, lat);
        end
    endtask

    task automatic test_digit4();
        logic [7:0] s, a, b;
        logic       c, co, ov, dnA, bsyA;
        int         lat, bc;
        logic [9:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            runOp(1, 8'h3C, 8'hA5, 1'b1, pass[0], s, co, ov, lat, bc, dnA, bsyA);
            checks++;
            if ({ov, co, s} !== {2'b00, 8'hE2} || lat !== 2 || bc !== 3 || dnA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL digit4 pass%0d: got res=%h lat=%0d busy=%0d doneAfter=%b expected 0E2 2 3 0",
                         pass, {ov, co, s}, lat, bc, dnA);
            end
        end
        for (int i = 0; i < 10; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            c   = 1'($urandom);
            exp = refAdd(8, a, b, c);
            runOp(1, a, b, c, 1'b1, s, co, ov, lat, bc, dnA, bsyA);
            checks++;
            if ({ov, co, s} !== exp || lat !== 2) begin
                errors++;
                $display("[TB] FAIL digit4 random %h+%h+%b: got %h lat=%0d expected %h lat=2", a, b, c, {ov, co, s}, lat, exp);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [7:0] s;
        logic       co, ov, dnA, bsyA;
        int         lat, bc;
        logic [9:0] exp;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp = refAdd(4, 8'(ai), 8'(bi), 1'(ci));
                    runOp(2, 8'(ai), 8'(bi), 1'(ci), 1'b0, s, co, ov, lat, bc, dnA, bsyA);
                    checks++;
                    if ({ov, co, s} !== exp || lat !== 4) begin
                        errors++;
                        $display("[TB] FAIL exhaustive4 %0d+%0d+%0d: got %h lat=%0d expected %h lat=4",
                                 ai, bi, ci, {ov, co, s}, lat, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_digit4();
        test_exhaustive4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
